term_text_writer: RTL and testbench

TERM_TEXT_WRITER -- requirements
Module: term_text_writer

---
 rtl/term_text_writer_if.sv | 19 +
 rtl/term_text_writer.sv | 196 +++++++++++++++++++
 tb/tb_term_text_writer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_text_writer_if.sv
// UART-receive and text-RAM write bundle for term_text_writer.
// master: byte source / RAM side; slave: the writer core.
interface term_text_writer_if;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;

  modport master (
    output rx_data_ready, rx_data,
    input  mem_we, mem_addr, mem_data
  );

  modport slave (
    input  rx_data_ready, rx_data,
    output mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/term_text_writer.sv
// Byte-stream terminal writer: FIFO-buffered UART bytes become text-RAM writes with cursor control.
// Macro TERM_SCROLL_EN: bottom-row newline scrolls via top_row instead of wrapping to row 0.
module term_text_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic                clk,
  input  logic                rst,
  term_text_writer_if.slave   bus,
  output logic [6:0]          cursor_col,
  output logic [4:0]          cursor_row,
  output logic [4:0]          top_row,
  output logic                busy,
  output logic                overflow
);
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned COL_W      = 7;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned ADDR_W     = 12;

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROW_W-1:0]    top_q, top_d;
  logic [COL_W-1:0]    clr_col_q, clr_col_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push_c, pop_c;

  logic [ROW_W:0]      row_sum_c;
  logic [ROW_W:0]      phys_row_c;
  logic [ADDR_W-1:0]   row_base_c;
  logic                newline_c;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Push may proceed into a full FIFO only when the head leaves in the same cycle
  always_comb begin
    pop_c   = (state_q == IDLE) && (count_q != '0);
    push_c  = bus.rx_data_ready && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_c);
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
    ovf_d   = ovf_q || (bus.rx_data_ready && !push_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // top_q and row_q are both < ROWS, so one conditional subtract wraps the sum
  always_comb begin
    row_sum_c  = (ROW_W+1)'(top_q) + (ROW_W+1)'(row_q);
    phys_row_c = (row_sum_c >= (ROW_W+1)'(ROWS)) ? row_sum_c - (ROW_W+1)'(ROWS) : row_sum_c;
    row_base_c = ADDR_W'(phys_row_c * COLS);
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    clr_col_d  = clr_col_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    newline_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop_c) begin
          byte_d  = fifo_mem[rd_ptr_q];
          state_d = EXEC;
          if (is_print(fifo_mem[rd_ptr_q])) begin
            mem_we_d   = 1'b1;
            mem_addr_d = row_base_c + ADDR_W'(col_q);
            mem_data_d = fifo_mem[rd_ptr_q];
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (is_print(byte_q)) begin
          if (col_q == COL_W'(COLS-1)) begin
            col_d     = '0;
            newline_c = 1'b1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else if (byte_q == 8'h0D) begin
          col_d = '0;
        end else if (byte_q == 8'h0A) begin
          newline_c = 1'b1;
        end else if (byte_q == 8'h08) begin
          if (col_q != '0) col_d = col_q - COL_W'(1);
        end

        if (newline_c) begin
          if (row_q != ROW_W'(ROWS-1)) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            state_d    = CLEAR;
            clr_col_d  = '0;
            mem_we_d   = 1'b1;
            mem_data_d = 8'h20;
`ifdef TERM_SCROLL_EN
            // After scrolling, the new bottom physical row is the old top row
            top_d      = (top_q == ROW_W'(ROWS-1)) ? '0 : top_q + ROW_W'(1);
            mem_addr_d = ADDR_W'(top_q * COLS);
`else
            row_d      = '0;
            mem_addr_d = '0;
`endif
          end
        end
      end
      CLEAR: begin
        if (clr_col_q == COL_W'(COLS-1)) begin
          state_d = IDLE;
        end else begin
          clr_col_d  = clr_col_q + COL_W'(1);
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          mem_data_d = 8'h20;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      clr_col_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      clr_col_q  <= clr_col_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;
  assign top_row      = top_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_term_text_writer.sv
// Directed bench for term_text_writer (default 80x30); expectations follow TERM_SCROLL_EN if defined.
module tb_term_text_writer;
  logic       clk;
  logic       rst;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic [4:0] top_row;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [11:0] wa [$];
  logic [7:0]  wd [$];
  int          wc [$];

  term_text_writer_if bus ();

  term_text_writer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .top_row    (top_row),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_data);
      wc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_data_ready = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data_ready = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic goto_bottom();
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    wait_idle();
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_data, cursor_col, cursor_row, top_row, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL %s: we=%b addr=%0d data=%h col=%0d row=%0d top=%0d busy=%b ovf=%b, required all 0",
               tag, bus.mem_we, bus.mem_addr, bus.mem_data, cursor_col, cursor_row, top_row, busy, overflow);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data_ready = 1'b0;
    bus.rx_data = 8'h00;
    #1;
    check_outputs_zero("reset_state");
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_held");
  endtask

  task automatic test_first_write();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_data_ready = 1'b1;
    bus.rx_data = 8'h41;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL first_we_early: mem_we=%b, required 0", bus.mem_we);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_data} !== {1'b1, 12'd0, 8'h41}) begin
      errors++;
      $display("FAIL first_write: we=%b addr=%0d data=%h, required we=1 addr=0 data=41",
               bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_we, cursor_col, cursor_row} !== {1'b0, 7'd1, 5'd0}) begin
      errors++;
      $display("FAIL first_cursor: we=%b col=%0d row=%0d, required we=0 col=1 row=0",
               bus.mem_we, cursor_col, cursor_row);
    end
  endtask

  task automatic test_text_sequence();
    do_reset();
    clear_log();
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h43);
    wait_idle();
    checks++;
    if (wa.size() != 3) begin
      errors++;
      $display("FAIL text_count: writes=%0d, required 3", wa.size());
    end else begin
      checks++;
      if ({wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !== {12'd0, 8'h41, 12'd1, 8'h42, 12'd80, 8'h43}) begin
        errors++;
        $display("FAIL text_writes: (%0d,%h) (%0d,%h) (%0d,%h), required (0,41) (1,42) (80,43)",
                 wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      end
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd1, 5'd1}) begin
      errors++;
      $display("FAIL text_cursor: col=%0d row=%0d, required col=1 row=1", cursor_col, cursor_row);
    end
  endtask

  task automatic test_backspace();
    clear_log();
    send_byte(8'h08);
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h7F);
    wait_idle();
    checks++;
    if ({cursor_col, cursor_row, 32'(wa.size())} !== {7'd0, 5'd1, 32'd0}) begin
      errors++;
      $display("FAIL backspace: col=%0d row=%0d writes=%0d, required col=0 row=1 writes=0",
               cursor_col, cursor_row, wa.size());
    end
  endtask

  task automatic test_line_wrap();
    int bad = 0;
    do_reset();
    clear_log();
    for (int i = 0; i < 80; i++) send_byte(8'h78);
    wait_idle();
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 12'(i) || wd[i] !== 8'h78) bad++;
    checks++;
    if (wa.size() != 80 || bad != 0) begin
      errors++;
      $display("FAIL wrap_writes: writes=%0d bad=%0d, required 80 writes to 0..79 with bad=0", wa.size(), bad);
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd0, 5'd1}) begin
      errors++;
      $display("FAIL wrap_cursor: col=%0d row=%0d, required col=0 row=1", cursor_col, cursor_row);
    end
  endtask

  task automatic test_bottom_wrap();
    int bad = 0;
    do_reset();
    goto_bottom();
    checks++;
    if (cursor_row !== 5'd29) begin
      errors++;
      $display("FAIL bottom_row: row=%0d, required 29", cursor_row);
    end
    clear_log();
    send_byte(8'h0A);
    wait_idle();
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 12'(i) || wd[i] !== 8'h20 || wc[i] != wc[0] + i) bad++;
    checks++;
    if (wa.size() != 80 || bad != 0) begin
      errors++;
      $display("FAIL clear_writes: writes=%0d bad=%0d, required 80 consecutive 0x20 writes to 0..79 with bad=0",
               wa.size(), bad);
    end
`ifdef TERM_SCROLL_EN
    checks++;
    if ({cursor_row, top_row, cursor_col} !== {5'd29, 5'd1, 7'd0}) begin
      errors++;
      $display("FAIL scroll_state: row=%0d top=%0d col=%0d, required row=29 top=1 col=0",
               cursor_row, top_row, cursor_col);
    end
`else
    checks++;
    if ({cursor_row, top_row, cursor_col} !== {5'd0, 5'd0, 7'd0}) begin
      errors++;
      $display("FAIL wrap_state: row=%0d top=%0d col=%0d, required row=0 top=0 col=0",
               cursor_row, top_row, cursor_col);
    end
`endif
    clear_log();
    send_byte(8'h5A);
    wait_idle();
    checks++;
    if (wa.size() != 1 || {wa[0], wd[0]} !== {12'd0, 8'h5A}) begin
      errors++;
      $display("FAIL after_clear_write: writes=%0d first=(%0d,%h), required 1 write (0,5a)",
               wa.size(), (wa.size() > 0) ? wa[0] : 12'd0, (wd.size() > 0) ? wd[0] : 8'd0);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    do_reset();
    goto_bottom();
    clear_log();
    send_byte(8'h0A);
    repeat (4) @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: overflow=%b, required 0", overflow);
    end
    bus.rx_data_ready = 1'b1;
    bus.rx_data = 8'h61;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      bus.rx_data = 8'h61 + 8'(k);
    end
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
    wait_idle();
    for (int i = 0; i < 80 && i < wa.size(); i++)
      if (wa[i] !== 12'(i) || wd[i] !== 8'h20) bad++;
    for (int i = 80; i < wa.size(); i++)
      if (wa[i] !== 12'(i - 80) || wd[i] !== 8'h61 + 8'(i - 80)) bad++;
    checks++;
    if (wa.size() != 84 || bad != 0) begin
      errors++;
      $display("FAIL ovf_writes: writes=%0d bad=%0d, required 84 (80 clears then 61..64 at 0..3) with bad=0",
               wa.size(), bad);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b, required 1", overflow);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    int g = 0;
    int sz;
    do_reset();
    goto_bottom();
    clear_log();
    send_byte(8'h0A);
    while (n < 10 && g < 300) begin
      @(negedge clk);
      g++;
      if (bus.mem_we === 1'b1) n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL mid_clear_reach: writes seen=%0d, required 10", n);
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_clear_reset");
    sz = wa.size();
    checks++;
    if (sz < 1 || wa[sz-1] !== 12'd9) begin
      errors++;
      $display("FAIL mid_clear_tenth: last addr=%0d, required 9", (sz > 0) ? wa[sz-1] : 12'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (wa.size() != sz) begin
      errors++;
      $display("FAIL post_reset_writes: writes=%0d, required %0d", wa.size(), sz);
    end
    check_outputs_zero("post_reset_idle");
  endtask

  initial begin
    bus.rx_data_ready = 1'b0;
    bus.rx_data = 8'h00;
    rst = 1'b1;
    test_reset();
    test_first_write();
    test_text_sequence();
    test_backspace();
    test_line_wrap();
    test_bottom_wrap();
    test_overflow();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
